// File: rtl/camera_fb_reader.sv
// Scans a row-major luma frame buffer in step with VGA timing and returns gray pixels 3 clocks later.
// Optional FB_THRESHOLD_EN: binarize active pixels against THRESH (laser-spot view).
module camera_fb_reader #(
  parameter int LOGSIZE = 19,
  parameter int WIDTH   = 8,
  parameter int HACTIVE = 640,
  parameter int VACTIVE = 480,
  parameter int THRESH  = 200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [10:0]        hcount,
  input  logic [9:0]         vcount,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               blank,
  output logic [LOGSIZE-1:0] bram_addr,
  input  logic [WIDTH-1:0]   bram_dout,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic               vga_blank,
  output logic [WIDTH-1:0]   pixel_out,
  output logic               frame_start
);

  localparam logic SYNC_WAIT = 1'b0;
  localparam logic RUN       = 1'b1;

  localparam logic [10:0]        H_ACT    = 11'(HACTIVE);
  localparam logic [9:0]         V_ACT    = 10'(VACTIVE);
  localparam logic [LOGSIZE-1:0] ADDR_MAX = LOGSIZE'(HACTIVE * VACTIVE - 1);
  localparam logic [WIDTH-1:0]   TH_VAL   = WIDTH'(THRESH);
`ifdef FB_THRESHOLD_EN
  localparam bit THR_EN = 1'b1;
`else
  localparam bit THR_EN = 1'b0;
`endif

  // Sync strobes travel as {hsync, vsync, blank}; idle value is blanked with syncs low.
  localparam logic [2:0] SYNC_IDLE = 3'b001;

  function automatic logic [WIDTH-1:0] pix_map(input logic [WIDTH-1:0] d);
    if (THR_EN) return (d >= TH_VAL) ? {WIDTH{1'b1}} : '0;
    return d;
  endfunction

  logic               state_q, state_d;
  logic [LOGSIZE-1:0] cnt_q, cnt_d;
  logic [LOGSIZE-1:0] bram_addr_q, bram_addr_d;
  logic               vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d;
  logic [2:0]         sync_p0_q, sync_p0_d, sync_p1_q, sync_p1_d, sync_p2_q, sync_p2_d;
  logic [WIDTH-1:0]   pixel_q, pixel_d;
  logic               frame_start_q, frame_start_d;
  logic               at_origin, run_now, active;

  always_comb begin
    at_origin = (hcount == 11'd0) && (vcount == 10'd0);
    // The origin cycle itself is already served as RUN so the frame starts at address 0.
    run_now   = (state_q == RUN) || at_origin;
    active    = run_now && (hcount < H_ACT) && (vcount < V_ACT);
    state_d   = run_now ? RUN : SYNC_WAIT;

    cnt_d       = cnt_q;
    bram_addr_d = bram_addr_q;
    if (!run_now) begin
      cnt_d       = '0;
      bram_addr_d = '0;
    end else if (vcount >= V_ACT) begin
      cnt_d = '0;
    end else if (active) begin
      bram_addr_d = cnt_q;
      cnt_d       = (cnt_q == ADDR_MAX) ? '0 : cnt_q + 1'b1;
    end

    // Stage p0: address register; p1: BRAM read; p2: output register.
    vld_p0_d      = active;
    sync_p0_d     = run_now ? {hsync, vsync, blank} : SYNC_IDLE;
    vld_p1_d      = vld_p0_q;
    sync_p1_d     = sync_p0_q;
    sync_p2_d     = sync_p1_q;
    pixel_d       = vld_p1_q ? pix_map(bram_dout) : '0;
    frame_start_d = at_origin;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SYNC_WAIT;
      cnt_q         <= '0;
      bram_addr_q   <= '0;
      vld_p0_q      <= 1'b0;
      vld_p1_q      <= 1'b0;
      sync_p0_q     <= SYNC_IDLE;
      sync_p1_q     <= SYNC_IDLE;
      sync_p2_q     <= SYNC_IDLE;
      pixel_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bram_addr_q   <= bram_addr_d;
      vld_p0_q      <= vld_p0_d;
      vld_p1_q      <= vld_p1_d;
      sync_p0_q     <= sync_p0_d;
      sync_p1_q     <= sync_p1_d;
      sync_p2_q     <= sync_p2_d;
      pixel_q       <= pixel_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bram_addr   = bram_addr_q;
  assign pixel_out   = pixel_q;
  assign vga_hsync   = sync_p2_q[2];
  assign vga_vsync   = sync_p2_q[1];
  assign vga_blank   = sync_p2_q[0];
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_camera_fb_reader.sv
// Directed bench for camera_fb_reader: a 640x480 instance plus a 16x4 instance for frame wrap.
module tb_camera_fb_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync, vsync, blank;
  logic [18:0] bram_addr;
  logic [7:0]  bram_dout;
  logic        vga_hsync, vga_vsync, vga_blank, frame_start;
  logic [7:0]  pixel_out;

  logic [10:0] hcount_s;
  logic [9:0]  vcount_s;
  logic        hsync_s, vsync_s, blank_s;
  logic [5:0]  bram_addr_s;
  logic [7:0]  bram_dout_s;
  logic        vga_hsync_s, vga_vsync_s, vga_blank_s, frame_start_s;
  logic [7:0]  pixel_out_s;

  camera_fb_reader dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .blank(blank),
    .bram_addr(bram_addr), .bram_dout(bram_dout),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank(vga_blank),
    .pixel_out(pixel_out), .frame_start(frame_start)
  );

  camera_fb_reader #(.LOGSIZE(6), .WIDTH(8), .HACTIVE(16), .VACTIVE(4), .THRESH(200)) dut_s (
    .clk(clk), .reset(reset), .hcount(hcount_s), .vcount(vcount_s),
    .hsync(hsync_s), .vsync(vsync_s), .blank(blank_s),
    .bram_addr(bram_addr_s), .bram_dout(bram_dout_s),
    .vga_hsync(vga_hsync_s), .vga_vsync(vga_vsync_s), .vga_blank(vga_blank_s),
    .pixel_out(pixel_out_s), .frame_start(frame_start_s)
  );

  // BRAM model: data = addr[7:0], one clock after the address, optionally overridden.
  logic       force_en = 1'b0;
  logic [7:0] force_val = 8'h00;
  always @(posedge clk) bram_dout <= force_en ? force_val : bram_addr[7:0];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected pixel/blank of the last three samples; [2] is what the outputs show after a step.
  logic [7:0] ep [0:2];
  logic       eb [0:2];
  logic       run_m   = 1'b0;
  logic       chk_pix = 1'b1;

  task automatic step(input int h, input int v);
    logic e_act;
    hcount = 11'(h);
    vcount = 10'(v);
    blank  = !(h < 640 && v < 480);
    hsync  = (h >= 656 && h < 752);
    vsync  = (v >= 490 && v < 492);
    if (reset) begin
      run_m = 1'b0;
      for (int i = 0; i < 3; i++) begin
        ep[i] = 8'h00;
        eb[i] = 1'b1;
      end
    end else begin
      if (h == 0 && v == 0) run_m = 1'b1;
      e_act = run_m && (h < 640) && (v < 480);
      ep[2] = ep[1]; ep[1] = ep[0];
      eb[2] = eb[1]; eb[1] = eb[0];
      ep[0] = e_act ? 8'((v * 640 + h) & 255) : 8'h00;
      eb[0] = run_m ? blank : 1'b1;
    end
    @(posedge clk); #1;
    if (chk_pix) begin
      check("pix_pipe", 32'(pixel_out), 32'(ep[2]));
      check("blank_pipe", 32'(vga_blank), 32'(eb[2]));
    end
  endtask

  task automatic step_s(input int h, input int v);
    hcount_s = 11'(h);
    vcount_s = 10'(v);
    blank_s  = !(h < 16 && v < 4);
    hsync_s  = 1'b0;
    vsync_s  = 1'b0;
    @(posedge clk); #1;
  endtask

  int fs_cnt;

  initial begin
    for (int i = 0; i < 3; i++) begin
      ep[i] = 8'h00;
      eb[i] = 1'b1;
    end
    bram_dout_s = 8'h00;
    hcount_s = 11'd100; vcount_s = 10'd10;
    hsync_s = 1'b0; vsync_s = 1'b0; blank_s = 1'b1;
    reset = 1'b1;
    step(100, 200);
    step(100, 200);
    check("rst_addr", 32'(bram_addr), 32'd0);
    check("rst_pix", 32'(pixel_out), 32'd0);
    check("rst_blank", 32'(vga_blank), 32'd1);
    check("rst_hsync", 32'(vga_hsync), 32'd0);
    check("rst_vsync", 32'(vga_vsync), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);

    reset = 1'b0;
    step(798, 524);
    step(799, 524);
    check("wait_addr", 32'(bram_addr), 32'd0);
    check("wait_fs", 32'(frame_start), 32'd0);

    // Lines 0 and 1 in full, line 2 up to pixel (5,2).
    fs_cnt = 0;
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 800; x++) begin
        if (y == 2 && x > 5) break;
        step(x, y);
        fs_cnt += int'(frame_start);
        if (x == 0 && y == 0) check("fs_first", 32'(frame_start), 32'd1);
        if (x < 640) check("addr_run", 32'(bram_addr), 32'(y * 640 + x));
        else if (y == 0) check("addr_hold", 32'(bram_addr), 32'd639);
        if (y == 0 && x == 642) check("pix_hblank", 32'(pixel_out), 32'd0);
        if (y == 0 && x == 655) check("hsync_low", 32'(vga_hsync), 32'd0);
        if (y == 0 && x == 658) check("hsync_high", 32'(vga_hsync), 32'd1);
        if (y == 1 && x == 2) check("pix_line1", 32'(pixel_out), 32'h80);
      end
    end
    check("fs_once", 32'(fs_cnt), 32'd1);
    step(6, 2);
    step(7, 2);
    check("pix_5_2", 32'(pixel_out), 32'h05);

    // Vertical blank clears the counter; next frame restarts at 0.
    step(700, 480);
    check("vblank_hold", 32'(bram_addr), 32'd1287);
    step(0, 481);
    step(799, 524);
    step(0, 0);
    check("f2_addr0", 32'(bram_addr), 32'd0);
    check("f2_fs", 32'(frame_start), 32'd1);
    step(1, 0);
    check("f2_addr1", 32'(bram_addr), 32'd1);

    // Data present on inactive cycles must not reach the output.
    chk_pix   = 1'b0;
    force_en  = 1'b1;
    force_val = 8'hAA;
    step(700, 0);
    step(701, 0);
    step(702, 0);
    check("pix_inact_data", 32'(pixel_out), 32'd0);
    force_val = 8'hC7;
    step(2, 0);
    step(3, 0);
    step(4, 0);
`ifdef FB_THRESHOLD_EN
    check("thr_199", 32'(pixel_out), 32'h00);
`else
    check("pix_c7", 32'(pixel_out), 32'hC7);
`endif
    force_val = 8'hC8;
    step(5, 0);
    step(6, 0);
    step(7, 0);
`ifdef FB_THRESHOLD_EN
    check("thr_200", 32'(pixel_out), 32'hFF);
`else
    check("pix_c8", 32'(pixel_out), 32'hC8);
`endif
    force_en = 1'b0;

    // Reset mid-frame: nothing until the next origin.
    reset = 1'b1;
    step(100, 200);
    reset   = 1'b0;
    chk_pix = 1'b1;
    for (int x = 101; x < 121; x++) begin
      step(x, 200);
      check("rst_mid_addr", 32'(bram_addr), 32'd0);
      check("rst_mid_fs", 32'(frame_start), 32'd0);
    end
    step(0, 1);
    check("rst_mid_addr_l1", 32'(bram_addr), 32'd0);
    step(0, 0);
    check("resume_fs", 32'(frame_start), 32'd1);
    check("resume_addr0", 32'(bram_addr), 32'd0);
    step(1, 0);
    check("resume_addr1", 32'(bram_addr), 32'd1);
    step(2, 0);
    check("resume_blank", 32'(vga_blank), 32'd0);
    step(3, 0);
    check("resume_pix", 32'(pixel_out), 32'd1);

    // Small frame: last active address and wrap straight into the next frame.
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 20; x++) begin
        step_s(x, y);
        if (x < 16) check("s_addr", 32'(bram_addr_s), 32'(y * 16 + x));
        else check("s_addr_hold", 32'(bram_addr_s), 32'(y * 16 + 15));
      end
    end
    check("s_last", 32'(bram_addr_s), 32'd63);
    step_s(0, 0);
    check("s_wrap", 32'(bram_addr_s), 32'd0);
    check("s_wrap_fs", 32'(frame_start_s), 32'd1);
    step_s(1, 0);
    check("s_wrap1", 32'(bram_addr_s), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/camera_fb_reader.md
CAMERA_FB_READER -- requirements
Module: camera_fb_reader

Interface
REQ-001 Parameter LOGSIZE, default 19: frame-buffer address width.
REQ-002 Parameter WIDTH, default 8: pixel (luma) width.
REQ-003 Parameter HACTIVE, default 640: active pixels per line.
REQ-004 Parameter VACTIVE, default 480: active lines per frame.
REQ-005 Parameter THRESH, default 200: binarize threshold, used only with the Configuration feature.
REQ-006 clk  in  1  system clock; reset is reset, synchronous, active-high; clock is clk.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 hcount  in  11  VGA horizontal position of the current cycle.
REQ-009 vcount  in  10  VGA vertical position of the current cycle.
REQ-010 hsync, vsync, blank  in  1 each  VGA timing strobes, aligned with hcount/vcount.
REQ-011 bram_addr  out  LOGSIZE  frame-buffer read address, registered.
REQ-012 bram_dout  in  WIDTH  frame-buffer read data, valid one clk after bram_addr.
REQ-013 vga_hsync, vga_vsync, vga_blank  out  1 each  timing strobes delayed to match pixel_out.
REQ-014 pixel_out  out  WIDTH  gray pixel to the VGA DAC.
REQ-015 frame_start  out  1  one-cycle pulse when a new frame read begins.

Function
REQ-016 The block SHALL read pixels stored row-major at address y*HACTIVE+x, the layout the camera writer produces.
REQ-017 States: SYNC_WAIT, RUN.
REQ-018 SYNC_WAIT: bram_addr held at 0, pixel_out 0, vga_blank 1; go to RUN on the first cycle with hcount==0 and vcount==0.
REQ-019 RUN: a cycle with hcount<HACTIVE and vcount<VACTIVE is active.
REQ-020 Address generation SHALL use a counter, no multiplier: on an active cycle bram_addr <= counter and counter increments.
REQ-021 counter SHALL clear to 0 on any cycle with vcount>=VACTIVE.
REQ-022 counter SHALL wrap 307199 -> 0 (HACTIVE*VACTIVE-1 -> 0) and never exceed it.
REQ-023 Inactive cycles (hcount>=HACTIVE, or vcount>=VACTIVE) SHALL not advance counter; the corresponding pixel_out SHALL be 0.
REQ-024 Latency: pixel_out, vga_hsync, vga_vsync and vga_blank SHALL correspond to inputs sampled exactly 3 cycles earlier (addr reg, BRAM read, output reg).
REQ-025 vga_hsync, vga_vsync and vga_blank SHALL pass through a 3-stage shift pipeline, unmodified in RUN.
REQ-026 frame_start SHALL pulse in the cycle after hcount==0 && vcount==0 is sampled in RUN, and on the SYNC_WAIT->RUN transition.
REQ-027 If bram_dout changes while its pixel is inactive, pixel_out SHALL still be 0; blanking wins over data.

Reset
REQ-028 On reset: state SYNC_WAIT, counter 0, bram_addr 0, pixel_out 0, vga_hsync 0, vga_vsync 0, vga_blank 1, frame_start 0, all pipeline stages cleared.
REQ-029 Reset mid-frame SHALL abandon the frame; output resumes only after the next hcount==0, vcount==0.

Configuration
REQ-030 Macro FB_THRESHOLD_EN: when defined, an active pixel_out SHALL be all-ones if bram_dout>=THRESH, else 0 (laser-spot view), with no added latency.
REQ-031 When FB_THRESHOLD_EN is undefined, an active pixel_out SHALL equal bram_dout.

Verification
REQ-032 Reset, then sweep to hcount=0,vcount=0 -> frame_start pulses once; bram_addr reads 0,1,2... on consecutive active cycles.
REQ-033 BRAM model returning data=addr[7:0]; pixel (5,2) sampled -> pixel_out=(2*640+5)&255=0x05 exactly 3 cycles later.
REQ-034 hcount=640..799 on line 0 -> bram_addr holds at 639, pixel_out 0 three cycles later; line 1 starts at 640.
REQ-035 vcount=480 -> counter 0; the next frame's first active pixel reads addr 0; the last active pixel reads 307199.
REQ-036 Reset asserted at pixel (100,200) -> pixel_out 0, vga_blank 1 until after the next (0,0); no address beyond 0 is issued before then.
REQ-037 FB_THRESHOLD_EN defined, THRESH=200: bram_dout=199 -> pixel_out 0x00; bram_dout=200 -> 0xFF.
